// File: rtl/reg_file_pkg.sv
// Shared widths, constants and helpers for the multi-port register file.
package reg_file_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_RD     = 3;
    localparam int ZERO_ADDR      = 0;

    typedef struct packed {
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] wa;
        logic [DEF_DATA_WIDTH-1:0] wd;
    } wr_port_t;

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with flush > set > clear priority and a population count.
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ZERO_REG   = 1,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  flush,
    input  logic [1:0]            clr_en,
    input  logic [2*ADDR_WIDTH-1:0] clr_addr,
    output logic [DEPTH-1:0]      busy,
    output logic [ADDR_WIDTH:0]   busy_cnt
);

    logic [DEPTH-1:0] busy_nxt;
    logic             set_ok;

    function automatic logic [ADDR_WIDTH:0] pop(input logic [DEPTH-1:0] v);
        logic [ADDR_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++)
            c = c + (ADDR_WIDTH+1)'(v[i]);
        return c;
    endfunction

    assign set_ok = set_en &&
        !(ZERO_REG != 0 && set_addr == ADDR_WIDTH'(ZERO_ADDR));

    // Later assignments override earlier ones, giving the priority order.
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < 2; k++)
            if (clr_en[k])
                busy_nxt[clr_addr[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b0;
        if (set_ok)
            busy_nxt[set_addr] = 1'b1;
        if (flush)
            busy_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= pop(busy_nxt);
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, write-first bypass,
// optional zero register and a busy-bit scoreboard for issue logic.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic [1:0]                   we,
    input  logic [2*ADDR_WIDTH-1:0]      wa,
    input  logic [2*DATA_WIDTH-1:0]      wd,
    input  logic                         set_en,
    input  logic [ADDR_WIDTH-1:0]        set_addr,
    input  logic                         flush,
    output logic [ADDR_WIDTH:0]          busy_cnt
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] wa;
        logic [DATA_WIDTH-1:0] wd;
    } wport_t;

    wport_t                wp [2];
    logic [1:0]            wr_ok;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      busy;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return ZERO_REG != 0 && a == ADDR_WIDTH'(ZERO_ADDR);
    endfunction

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            wp[k].we = we[k];
            wp[k].wa = wa[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];
            wp[k].wd = wd[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
            wr_ok[k] = wp[k].we && !is_zero(wp[k].wa);
        end
    end

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wr_ok[0])
                mem[wp[0].wa] <= wp[0].wd;
            if (wr_ok[1])
                mem[wp[1].wa] <= wp[1].wd;
        end
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_addr (set_addr),
        .flush    (flush),
        .clr_en   (wr_ok),
        .clr_addr ({wp[1].wa, wp[0].wa}),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        logic                  h0;
        logic                  h1;
        logic [DATA_WIDTH-1:0] d;

        assign a  = ra[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
        assign h0 = wr_ok[0] && wp[0].wa == a;
        assign h1 = wr_ok[1] && wp[1].wa == a;

        always_comb begin
            d = is_zero(a) ? '0 : mem[a];
            unique case (1'b1)
                h1:        d = wp[1].wd;
                h0 && !h1: d = wp[0].wd;
                default:   ;
            endcase
        end

        assign rd[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] = rst ? '0 : d;
        assign rd_busy[i] = !rst && busy[a] && !(h0 || h1);
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp, with ZERO_REG=1 and ZERO_REG=0 instances.
module tb_reg_file_mp;

    logic        clk;
    logic        rst;
    logic [14:0] ra;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        set_en;
    logic [4:0]  set_addr;
    logic        flush;

    logic [95:0] rd;
    logic [2:0]  rd_busy;
    logic [5:0]  busy_cnt;
    logic [95:0] rd_z;
    logic [2:0]  rd_busy_z;
    logic [5:0]  busy_cnt_z;

    int errors;
    int checks;

    reg_file_mp #(.ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rd_busy(rd_busy),
        .we(we), .wa(wa), .wd(wd), .set_en(set_en),
        .set_addr(set_addr), .flush(flush), .busy_cnt(busy_cnt)
    );

    reg_file_mp #(.ZERO_REG(0)) u_dz (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_z), .rd_busy(rd_busy_z),
        .we(we), .wa(wa), .wd(wd), .set_en(set_en),
        .set_addr(set_addr), .flush(flush), .busy_cnt(busy_cnt_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input int p, input logic [4:0] a);
        ra[p*5 +: 5] = a;
    endtask

    task automatic wr(input int p, input logic [4:0] a,
                      input logic [31:0] d);
        we[p] = 1'b1;
        wa[p*5 +: 5] = a;
        wd[p*32 +: 32] = d;
    endtask

    function automatic logic [31:0] rdp(input int p);
        return rd[p*32 +: 32];
    endfunction

    function automatic logic [31:0] rdzp(input int p);
        return rd_z[p*32 +: 32];
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        ra = '0;
        we = '0;
        wa = '0;
        wd = '0;
        set_en = 1'b0;
        set_addr = '0;
        flush = 1'b0;
        #1;
        chk("rst_rd", 64'(rd), 64'h0);
        chk("rst_cnt", 64'(busy_cnt), 64'h0);
        tick();
        tick();
        rst = 1'b0;

        // Some state, then reset mid-run.
        wr(0, 5'd7, 32'hA);
        set_en = 1'b1;
        set_addr = 5'd2;
        tick();
        we = '0;
        set_en = 1'b0;
        set_ra(0, 5'd7);
        #1;
        chk("pre_rst_r7", 64'(rdp(0)), 64'hA);
        chk("pre_rst_cnt", 64'(busy_cnt), 64'd1);
        wr(0, 5'd6, 32'h55);
        set_ra(1, 5'd2);
        set_ra(2, 5'd6);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd", 64'(rd), 64'h0);
        chk("mid_rst_busy", 64'(rd_busy), 64'h0);
        chk("mid_rst_cnt", 64'(busy_cnt), 64'h0);
        tick();
        rst = 1'b0;
        we = '0;
        #1;
        chk("post_rst_r6", 64'(rdp(2)), 64'h0);
        chk("post_rst_r7", 64'(rdp(0)), 64'h0);
        chk("post_rst_busy", 64'(rd_busy), 64'h0);

        // Zero register.
        wr(0, 5'd0, 32'hDEADBEEF);
        set_en = 1'b1;
        set_addr = 5'd0;
        set_ra(0, 5'd0);
        #1;
        chk("r0_bypass", 64'(rdp(0)), 64'h0);
        chk("r0_bypass_z0", 64'(rdzp(0)), 64'hDEADBEEF);
        tick();
        we = '0;
        set_en = 1'b0;
        #1;
        chk("r0_read", 64'(rdp(0)), 64'h0);
        chk("r0_busy", 64'(rd_busy[0]), 64'h0);
        chk("r0_cnt", 64'(busy_cnt), 64'h0);
        chk("r0_read_z0", 64'(rdzp(0)), 64'hDEADBEEF);
        chk("r0_busy_z0", 64'(rd_busy_z[0]), 64'h1);
        chk("r0_cnt_z0", 64'(busy_cnt_z), 64'd1);

        // Dual write collision.
        wr(0, 5'd5, 32'h22222222);
        wr(1, 5'd5, 32'h11111111);
        set_ra(1, 5'd5);
        #1;
        chk("coll_bypass", 64'(rdp(1)), 64'h11111111);
        tick();
        we = '0;
        #1;
        chk("coll_stored", 64'(rdp(1)), 64'h11111111);

        // Bypass.
        wr(0, 5'd7, 32'hA);
        tick();
        we = '0;
        set_ra(0, 5'd7);
        #1;
        chk("r7_hold", 64'(rdp(0)), 64'hA);
        wr(0, 5'd7, 32'hB);
        #1;
        chk("byp_p0", 64'(rdp(0)), 64'hB);
        wr(1, 5'd7, 32'hC);
        #1;
        chk("byp_p1", 64'(rdp(0)), 64'hC);
        tick();
        we = '0;
        #1;
        chk("byp_stored", 64'(rdp(0)), 64'hC);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_cnt_z0", 64'(busy_cnt_z), 64'd0);

        // Scoreboard lifecycle.
        set_en = 1'b1;
        set_addr = 5'd9;
        tick();
        set_en = 1'b0;
        set_ra(2, 5'd9);
        #1;
        chk("r9_busy", 64'(rd_busy[2]), 64'h1);
        chk("r9_cnt", 64'(busy_cnt), 64'd1);
        wr(1, 5'd9, 32'h99);
        #1;
        chk("r9_wb_busy", 64'(rd_busy[2]), 64'h0);
        chk("r9_wb_data", 64'(rdp(2)), 64'h99);
        tick();
        we = '0;
        #1;
        chk("r9_clr_busy", 64'(rd_busy[2]), 64'h0);
        chk("r9_clr_cnt", 64'(busy_cnt), 64'd0);
        chk("r9_data", 64'(rdp(2)), 64'h99);

        // Set beats write; flush beats set.
        set_en = 1'b1;
        set_addr = 5'd3;
        wr(0, 5'd3, 32'h33);
        tick();
        set_en = 1'b0;
        we = '0;
        set_ra(0, 5'd3);
        #1;
        chk("race_busy", 64'(rd_busy[0]), 64'h1);
        chk("race_data", 64'(rdp(0)), 64'h33);
        chk("race_cnt", 64'(busy_cnt), 64'd1);
        set_en = 1'b1;
        set_addr = 5'd4;
        flush = 1'b1;
        tick();
        set_en = 1'b0;
        flush = 1'b0;
        set_ra(1, 5'd4);
        #1;
        chk("fl_cnt", 64'(busy_cnt), 64'd0);
        chk("fl_busy", 64'(rd_busy), 64'h0);

        // Fill and count.
        for (int a = 1; a < 32; a++) begin
            set_en = 1'b1;
            set_addr = 5'(a);
            tick();
        end
        set_en = 1'b0;
        #1;
        chk("fill_cnt", 64'(busy_cnt), 64'd31);
        chk("fill_cnt_z0", 64'(busy_cnt_z), 64'd31);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("fill_flush", 64'(busy_cnt), 64'd0);
        for (int a = 0; a < 32; a++) begin
            set_en = 1'b1;
            set_addr = 5'(a);
            tick();
        end
        set_en = 1'b0;
        set_ra(0, 5'd0);
        #1;
        chk("fill32_cnt", 64'(busy_cnt), 64'd31);
        chk("fill32_cnt_z0", 64'(busy_cnt_z), 64'd32);
        chk("fill32_r0", 64'(rd_busy[0]), 64'h0);
        chk("fill32_r0_z0", 64'(rd_busy_z[0]), 64'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("fill32_flush_z0", 64'(busy_cnt_z), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
